// File: rtl/miriscv_irq_ctrl.sv
// miriscv_irq_ctrl: picks one pending, enabled request line, pulses int_o with the matching
// mcause, and answers the core's mret (int_rst_i) with a one-cycle one-hot int_fin_o.
// Default arbitration is a round-robin scan pointer stepping one line per cycle.
// Define MIRISCV_IRQ_PRIORITY_EN to use a fixed-priority encoder (lowest index wins) instead.
module miriscv_irq_ctrl #(
  parameter int unsigned N_IRQ = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [N_IRQ-1:0] int_req_i,
  input  logic [N_IRQ-1:0] mie_i,
  input  logic             int_rst_i,
  output logic             int_o,
  output logic [31:0]      mcause_o,
  output logic [N_IRQ-1:0] int_fin_o
);

  localparam int unsigned IdxW = $clog2(N_IRQ);

  typedef enum logic {StScan, StServe} state_e;

  state_e          state_q;
  logic [IdxW-1:0] idx_q;
  logic            hit;
  logic [IdxW-1:0] sel;

`ifdef MIRISCV_IRQ_PRIORITY_EN
  logic [N_IRQ-1:0] pending;

  assign pending = int_req_i & mie_i;
  assign hit     = |pending;

  // Lowest enabled pending line wins; the descending loop lets smaller indices overwrite
  always_comb begin
    sel = '0;
    for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
      if (pending[i]) sel = IdxW'(i);
    end
  end
`else
  logic [IdxW-1:0] cnt_q;

  // Only the line under the scan pointer is considered each cycle
  assign sel = cnt_q;
  assign hit = int_req_i[cnt_q] & mie_i[cnt_q];
`endif

  // Controller FSM with registered outputs; reset silently drops any handler in progress
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= StScan;
      idx_q     <= '0;
`ifndef MIRISCV_IRQ_PRIORITY_EN
      cnt_q     <= '0;
`endif
      int_o     <= 1'b0;
      mcause_o  <= '0;
      int_fin_o <= '0;
    end else begin
      int_o     <= 1'b0;
      int_fin_o <= '0;
      unique case (state_q)
        StScan: begin
          if (hit) begin
            idx_q    <= sel;
            state_q  <= StServe;
            int_o    <= 1'b1;
            mcause_o <= {1'b1, {(31 - IdxW){1'b0}}, sel};
          end else begin
`ifndef MIRISCV_IRQ_PRIORITY_EN
            cnt_q <= cnt_q + IdxW'(1);
`endif
          end
        end
        StServe: begin
          // Request lines are ignored here: a line dropped mid-handler still gets its ack
          if (int_rst_i) begin
            int_fin_o <= {{(N_IRQ - 1){1'b0}}, 1'b1} << idx_q;
`ifndef MIRISCV_IRQ_PRIORITY_EN
            // Resume just past the served line so every source gets a turn
            cnt_q     <= idx_q + IdxW'(1);
`endif
            state_q   <= StScan;
          end
        end
        default: state_q <= StScan;
      endcase
    end
  end

endmodule

// File: tb/tb_miriscv_irq_ctrl.sv
// Self-checking bench for miriscv_irq_ctrl: directed scenarios plus a randomized phase, all
// outputs compared every cycle against a behavioural model of the arbitration rules.
module tb_miriscv_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] int_req;
  logic [31:0] mie;
  logic        int_rst;
  logic        irq;
  logic [31:0] mcause;
  logic [31:0] fin;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  bit          auto_drop = 1'b1;

  // Behavioural model state
  bit          m_busy;
  int          m_ptr;
  int          m_cur;
  logic        m_int;
  logic [31:0] m_mcause;
  logic [31:0] m_fin;

`ifdef MIRISCV_IRQ_PRIORITY_EN
  localparam int FirstLat = 1;
  localparam logic [4:0] FairSeq [4] = '{5'd0, 5'd0, 5'd0, 5'd0};
`else
  localparam int FirstLat = 6;
  localparam logic [4:0] FairSeq [4] = '{5'd0, 5'd5, 5'd0, 5'd5};
`endif

  miriscv_irq_ctrl #(.N_IRQ(32)) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .int_req_i (int_req),
    .mie_i     (mie),
    .int_rst_i (int_rst),
    .int_o     (irq),
    .mcause_o  (mcause),
    .int_fin_o (fin)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy   = 1'b0;
    m_ptr    = 0;
    m_cur    = 0;
    m_int    = 1'b0;
    m_mcause = '0;
    m_fin    = '0;
  endtask

  // One clock edge of the arbitration rules, using the inputs stable at that edge
  task automatic model_step();
    int pick;
    pick = -1;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_int = 1'b0;
    m_fin = '0;
    if (!m_busy) begin
`ifdef MIRISCV_IRQ_PRIORITY_EN
      for (int i = 31; i >= 0; i--) if (int_req[i] && mie[i]) pick = i;
`else
      if (int_req[m_ptr] && mie[m_ptr]) pick = m_ptr;
      else m_ptr = (m_ptr + 1) % 32;
`endif
      if (pick >= 0) begin
        m_busy   = 1'b1;
        m_cur    = pick;
        m_int    = 1'b1;
        m_mcause = 32'h8000_0000 + 32'(pick);
      end
    end else if (int_rst) begin
      m_fin  = 32'd1 << m_cur;
      m_ptr  = (m_cur + 1) % 32;
      m_busy = 1'b0;
    end
  endtask

  // Advance one cycle: model at the rising edge, compare at the falling edge
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_eq("int_o", {31'b0, irq}, {31'b0, m_int});
    check_eq("mcause", mcause, m_mcause);
    check_eq("int_fin", fin, m_fin);
    if (auto_drop && fin != 32'd0) int_req = int_req & ~fin;
  endtask

  task automatic wait_int(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!irq && n < 40);
    if (!irq) check_eq("wait_int_o", {31'b0, irq}, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_int_o"}, {31'b0, irq}, 32'd0);
    check_eq({tag, "_mcause"}, mcause, 32'd0);
    check_eq({tag, "_fin"}, fin, 32'd0);
  endtask

  initial begin
    int n;
    int cnt;
    int cd;
    logic [4:0] seq [4];

    rst_n   = 1'b1;
    int_req = 32'hFFFF_FFFF;
    mie     = 32'hFFFF_FFFF;
    int_rst = 1'b0;
    model_reset();

    // Reset values with every line requesting
    #1 rst_n = 1'b0;
    #1 check_all_zero("t1");
    tick();
    tick();
    check_all_zero("t1_hold");

    // Single line 5
    int_req = 32'h20;
    rst_n   = 1'b1;
    wait_int(n);
    check_eq("t2_latency", n, FirstLat);
    check_eq("t2_mcause", mcause, 32'h8000_0005);
    int_rst = 1'b1;
    tick();
    int_rst = 1'b0;
    check_eq("t2_fin", fin, 32'h20);
    tick();
    check_eq("t2_fin_clear", fin, 32'h0);

    // Masked line 19
    mie     = 32'h0;
    int_req = 32'h8_0000;
    cnt     = 0;
    repeat (100) begin
      tick();
      if (irq) cnt++;
    end
    check_eq("t3_masked", cnt, 0);
    mie = 32'h8_0000;
    wait_int(n);
    check_eq("t3_mcause", mcause, 32'h8000_0013);
    int_rst = 1'b1;
    tick();
    int_rst = 1'b0;
    check_eq("t3_fin", fin, 32'h8_0000);

    // Fairness between lines 0 and 5, both held
    auto_drop = 1'b0;
    mie       = 32'hFFFF_FFFF;
    int_req   = 32'h21;
    for (int k = 0; k < 4; k++) begin
      wait_int(n);
      seq[k] = mcause[4:0];
      repeat (4) tick();
      int_rst = 1'b1;
      tick();
      int_rst = 1'b0;
    end
    for (int k = 0; k < 4; k++) check_eq($sformatf("t4_seq%0d", k), {27'b0, seq[k]},
                                         {27'b0, FairSeq[k]});
    int_req   = 32'h0;
    auto_drop = 1'b1;

    // Stray completion while scanning
    repeat (3) tick();
    int_rst = 1'b1;
    tick();
    int_rst = 1'b0;
    check_eq("t5_fin", fin, 32'h0);
    tick();
    check_eq("t5_fin_next", fin, 32'h0);

    // Reset in the middle of serving line 5
    int_req = 32'h20;
    wait_int(n);
    check_eq("t6_mcause", mcause, 32'h8000_0005);
    tick();
    tick();
    rst_n = 1'b0;
    #1 check_all_zero("t6");
    model_reset();
    tick();
    check_eq("t6_fin_hold", fin, 32'h0);
    tick();
    check_all_zero("t6_hold");
    rst_n   = 1'b1;
    int_req = 32'h0;

    // Randomized traffic with a responsive core and requesters
    cd = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) int_req[$urandom_range(31)] = 1'b1;
      if ($urandom_range(63) == 0) mie = ($urandom_range(1) == 0) ? 32'hFFFF_FFFF : $urandom;
      int_rst = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) int_rst = 1'b1;
      end else if ($urandom_range(49) == 0) begin
        int_rst = 1'b1;
      end
      if ($urandom_range(799) == 0) begin
        rst_n = 1'b0;
        #1 check_all_zero("rnd_rst");
        model_reset();
        cd      = 0;
        int_rst = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      tick();
      if (irq) cd = $urandom_range(6, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
